// File: rtl/barrel_unshifter_pipe_if.sv
// Handshake bundle for barrel_unshifter_pipe: input word/amount channel and restored-word output channel.
// BARREL_UNSHIFT_DIR_EN adds the in_dir signal carried with each input word.
interface barrel_unshifter_pipe_if #(
    parameter int WIDTH = 4,
    parameter int SW    = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SW-1:0]    in_shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef BARREL_UNSHIFT_DIR_EN
    logic             in_dir;

    modport master (
        output in_valid, in_data, in_shamt, in_dir, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_data, in_shamt, in_dir, out_ready,
        output in_ready, out_valid, out_data
    );
`else
    modport master (
        output in_valid, in_data, in_shamt, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_data, in_shamt, out_ready,
        output in_ready, out_valid, out_data
    );
`endif
endinterface

// File: rtl/barrel_unshifter_pipe.sv
// Pipelined inverse rotator: undoes a left rotate by rotating right by the same amount, one log2 stage per register.
// BARREL_UNSHIFT_DIR_EN adds a per-word in_dir (1 = rotate left, undoing a right-rotate encoder).
module barrel_unshifter_pipe #(
    parameter int WIDTH = 4,
    parameter int SW    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    barrel_unshifter_pipe_if.slave  bus
);

    logic [SW-1:0]    r_valid;
    logic [WIDTH-1:0] r_data  [SW];
    logic [SW-1:0]    r_shamt [SW];
`ifdef BARREL_UNSHIFT_DIR_EN
    logic [SW-1:0]    r_dir;
`endif

    logic [SW-1:0]    w_load;
    logic [SW-1:0]    w_src_valid;
    logic [SW-1:0]    w_src_dir;
    logic [WIDTH-1:0] w_src_data  [SW];
    logic [SW-1:0]    w_src_shamt [SW];
    logic [WIDTH-1:0] w_nxt_data  [SW];

    function automatic logic [WIDTH-1:0] f_rot(input logic [WIDTH-1:0] d, input int n, input logic left);
        logic [2*WIDTH-1:0] dd;
        logic [2*WIDTH-1:0] sh;
        dd = {d, d};
        if (left) begin
            sh = dd << n;
            return sh[2*WIDTH-1:WIDTH];
        end
        sh = dd >> n;
        return sh[WIDTH-1:0];
    endfunction

    // Handshake: a word moves on a rising edge when valid & ready are both high. A stage loads when it
    // is empty or its successor loads; the last stage loads when empty or out_ready. in_ready is the
    // stage-0 load condition, so ready ripples combinationally back from out_ready (no skid buffer).
    always_comb begin
        w_load = '0;
        w_load[SW-1] = !r_valid[SW-1] || bus.out_ready;
        for (int j = SW - 2; j >= 0; j--) begin
            w_load[j] = !r_valid[j] || w_load[j+1];
        end
    end

    always_comb begin
        w_src_valid    = '0;
        w_src_dir      = '0;
        w_src_valid[0] = bus.in_valid;
        w_src_data[0]  = bus.in_data;
        w_src_shamt[0] = bus.in_shamt;
`ifdef BARREL_UNSHIFT_DIR_EN
        w_src_dir[0]   = bus.in_dir;
`endif
        for (int j = 1; j < SW; j++) begin
            w_src_valid[j] = r_valid[j-1];
            w_src_data[j]  = r_data[j-1];
            w_src_shamt[j] = r_shamt[j-1];
`ifdef BARREL_UNSHIFT_DIR_EN
            w_src_dir[j]   = r_dir[j-1];
`endif
        end
        // Stage j only owns shamt bit j; the full amount travels along so later stages can pick their bit.
        for (int j = 0; j < SW; j++) begin
            w_nxt_data[j] = w_src_shamt[j][j] ? f_rot(w_src_data[j], 1 << j, w_src_dir[j])
                                              : w_src_data[j];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
`ifdef BARREL_UNSHIFT_DIR_EN
            r_dir   <= '0;
`endif
            for (int j = 0; j < SW; j++) begin
                r_data[j]  <= '0;
                r_shamt[j] <= '0;
            end
        end else begin
            for (int j = 0; j < SW; j++) begin
                if (w_load[j]) begin
                    r_valid[j] <= w_src_valid[j];
                    if (w_src_valid[j]) begin
                        r_data[j]  <= w_nxt_data[j];
                        r_shamt[j] <= w_src_shamt[j];
`ifdef BARREL_UNSHIFT_DIR_EN
                        r_dir[j]   <= w_src_dir[j];
`endif
                    end
                end
            end
        end
    end

    assign bus.in_ready  = w_load[0];
    assign bus.out_valid = r_valid[SW-1];
    assign bus.out_data  = r_data[SW-1];

endmodule

// File: tb/tb_barrel_unshifter_pipe.sv
// Directed bench for barrel_unshifter_pipe with a queue scoreboard; define BARREL_UNSHIFT_DIR_EN
// to also exercise the direction input.
module tb_barrel_unshifter_pipe;

    localparam int W  = 4;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst;
    logic tb_dir = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    logic [W-1:0] exp_q[$];

    barrel_unshifter_pipe_if #(.WIDTH(W), .SW(SW)) bus();

    barrel_unshifter_pipe #(.WIDTH(W), .SW(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #1000000;
        $display("FAIL watchdog: obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Independent reference: out[k] = d[(k + s) mod W] for right, d[(k - s) mod W] for left.
    function automatic logic [W-1:0] model(input logic [W-1:0] d, input int s, input logic left);
        logic [W-1:0] r;
        for (int k = 0; k < W; k++) begin
            r[k] = left ? d[(k - s + W) % W] : d[(k + s) % W];
        end
        return r;
    endfunction

    // Scoreboard: sampled on the falling edge, reflecting what the next rising edge will transfer.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_out", bus.out_valid, 1'b0);
                else                   chk("sb_data", bus.out_data, exp_q.pop_front());
            end
            if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.in_data, bus.in_shamt, tb_dir));
        end
    end

    task automatic send(input logic [W-1:0] d, input logic [SW-1:0] s, input logic dir);
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_shamt = s;
        tb_dir       = dir;
`ifdef BARREL_UNSHIFT_DIR_EN
        bus.in_dir   = dir;
`endif
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_bound", 32'(n < 50), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_q", exp_q.size(), 0);
        chk("drain_valid", bus.out_valid, 1'b0);
    endtask

    initial begin
        logic [W-1:0] held;
        int c0;
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 4'hA;
        bus.in_shamt  = 2'd1;
        bus.out_ready = 1'b1;
`ifdef BARREL_UNSHIFT_DIR_EN
        bus.in_dir    = 1'b0;
`endif

        // Reset with in_valid asserted
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data", bus.out_data, 4'h0);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("rst_in_ready", bus.in_ready, 1'b1);

        // Single word, latency 2
        send(4'b1100, 2'd1, 1'b0);
        chk("lat_early", bus.out_valid, 1'b0);
        @(posedge clk);
        #1;
        chk("lat_valid", bus.out_valid, 1'b1);
        chk("single_data", bus.out_data, 4'b0110);
        wait_drain();

        // Full sweep back-to-back, one word per cycle
        c0 = cyc;
        for (int d = 0; d < 16; d++) begin
            for (int s = 0; s < 4; s++) begin
                send(W'(d), SW'(s), 1'b0);
            end
        end
        chk("sweep_rate", cyc - c0, 64);
        wait_drain();

        // Random burst
        for (int i = 0; i < 20; i++) begin
            send(W'($urandom_range(15, 0)), SW'($urandom_range(3, 0)), 1'b0);
        end
        wait_drain();

        // Backpressure: two words held, output stable, then released in order
        bus.out_ready = 1'b0;
        send(4'b1001, 2'd3, 1'b0);
        send(4'b0111, 2'd2, 1'b0);
        held = model(4'b1001, 3, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'b1110;
        bus.in_shamt = 2'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", bus.in_ready, 1'b0);
            chk("bp_out_valid", bus.out_valid, 1'b1);
            chk("bp_out_data", bus.out_data, held);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(4'b1110, 2'd1, 1'b0);
        wait_drain();

        // Reset mid-flight discards both words
        bus.out_ready = 1'b0;
        send(4'b0101, 2'd1, 1'b0);
        send(4'b0011, 2'd2, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_out_valid", bus.out_valid, 1'b0);
        chk("midrst_in_ready", bus.in_ready, 1'b1);
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_no_ghost", bus.out_valid, 1'b0);
        wait_drain();

`ifdef BARREL_UNSHIFT_DIR_EN
        send(4'b0011, 2'd1, 1'b1);
        @(posedge clk);
        #1;
        chk("dir_left", bus.out_data, 4'b0110);
        wait_drain();
        send(4'b0011, 2'd1, 1'b0);
        @(posedge clk);
        #1;
        chk("dir_right", bus.out_data, 4'b1001);
        wait_drain();
        for (int s = 0; s < 4; s++) begin
            send(4'b1011, SW'(s), 1'b1);
        end
        wait_drain();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
